lsu_dmem: RTL and testbench
===========================

LSU_DMEM -- requirements
Module: lsu_dmem

Interface
REQ-001 SHALL have parameter n, default 32, meaning data/address width in bits.
REQ-002 SHALL have parameter alen, default 8, meaning word-address bits (RAM depth 2^alen words).
REQ-003 SHALL have parameter WAITC, default 1, meaning wait-state cycles per access (0..15).
REQ-004 SHALL have port clock  input  1  meaning single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  meaning access request, sampled only in IDLE.
REQ-007 SHALL have port we  input  1  meaning 1 = store, 0 = load.
REQ-008 SHALL have port funct3  input  3  meaning RISC-V load/store width and sign field.
REQ-009 SHALL have port addr  input  n  meaning byte address (ALU output).
REQ-010 SHALL have port wdata  input  n  meaning store data (rs2 value).
REQ-011 SHALL have port busy  output  1  meaning access in progress; stalls the program counter.
REQ-012 SHALL have port valid  output  1  meaning one-cycle completion pulse.
REQ-013 SHALL have port rdata  output  n  meaning extended load result for the register write-back mux.
REQ-014 SHALL have port err  output  1  meaning one-cycle pulse for a misaligned or illegal request.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, DONE, ERR.
REQ-016 SHALL, in IDLE with req=1, latch we/funct3/addr/wdata and check legality; IDLE with req=0 stays IDLE.
REQ-017 SHALL treat as illegal: funct3 011/110/111; funct3 100/101 with we=1; halfword with addr[0]=1; word with addr[1:0]!=0.
REQ-018 SHALL, on an illegal request, go IDLE->ERR, then ERR->IDLE; err=1 only in ERR, valid stays 0, memory and rdata unchanged.
REQ-019 SHALL, on a legal request, go to WAIT loaded with WAITC-1 when WAITC>=1, or directly to DONE when WAITC=0.
REQ-020 SHALL decrement the WAIT counter each cycle and go WAIT->DONE when it reads 0.
REQ-021 SHALL perform the RAM access on the edge entering DONE: stores write byte lanes only, loads register the result into rdata.
REQ-022 SHALL drive busy=1 exactly in WAIT and valid=1 exactly in DONE; DONE->IDLE unconditionally.
REQ-023 SHALL complete a legal request accepted at edge k with valid high in cycle k+WAITC+1.
REQ-024 SHALL index words by addr[alen+1:2] and ignore upper address bits, so addresses wrap modulo 2^(alen+2).
REQ-025 SHALL select lanes by addr[1:0]: SB one byte, SH two bytes, SW all four bytes.
REQ-026 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results to n bits.
REQ-027 SHALL hold rdata until the next completed load; stores and errors SHALL NOT change it.
REQ-028 SHALL ignore req while in WAIT, DONE or ERR, so back-to-back requests are accepted only in IDLE.

Reset
REQ-029 SHALL, while reset=0, asynchronously force state=IDLE, counter=0, busy=0, valid=0, err=0, rdata=0.
REQ-030 SHALL abort any access pending mid-WAIT on reset without writing RAM; RAM contents are not reset.

Structure
REQ-031 SHALL place the state enum, funct3 constants (LB..LHU/SB..SW) and the default WAITC in shared package lsu_pkg.
REQ-032 SHALL instantiate one sub-module dmem_ram: a synchronous 2^alen x n RAM with a 4-bit byte-enable write and registered read.

Verification
REQ-033 SHALL cover SW 0xDEADBEEF at addr 0x10, then LW at 0x10: rdata=0xDEADBEEF, valid in cycle k+2 with WAITC=1, busy high exactly one cycle.
REQ-034 SHALL cover, after REQ-033, LB at 0x13 -> 0xFFFFFFDE, LBU at 0x13 -> 0x000000DE, LH at 0x10 -> 0xFFFFBEEF, LHU at 0x12 -> 0x0000DEAD.
REQ-035 SHALL cover SB 0x55 at 0x11 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
REQ-036 SHALL cover LW at 0x12 and SB with funct3 100: err pulses one cycle, valid=0, memory unchanged, rdata unchanged.
REQ-037 SHALL cover reset asserted mid-WAIT of SW 0x12345678 at 0x20 (WAITC=3): outputs zero immediately, and a subsequent LW 0x20 returns the prior contents.
REQ-038 SHALL cover req held high continuously: accepted only in IDLE, one valid per access, and addr 0x410 aliases 0x10 when alen=8.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds the access FSM states, funct3 encodings and legality check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int DEF_WAITC = 1;

  function automatic logic lsu_legal(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok;
    ok = 1'b0;
    unique case (f3)
      LB:      ok = 1'b1;
      LH:      ok = ~a[0];
      LW:      ok = (a == 2'b00);
      LBU:     ok = ~we;
      LHU:     ok = ~we;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_dmem_ram.sv
// Word-organised data RAM with byte-lane writes and a registered read.
// Contents are deliberately left unreset.
module dmem_ram #(
  parameter int n    = 32,
  parameter int alen = 8
) (
  input  logic            clock,
  input  logic            i_we,
  input  logic            i_re,
  input  logic [3:0]      i_be,
  input  logic [alen-1:0] i_addr,
  input  logic [n-1:0]    i_wdata,
  output logic [n-1:0]    o_rdata
);

  logic [n-1:0] r_mem [2**alen];
  logic [n-1:0] r_q;

  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (i_re) begin
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit in front of a wait-stated data RAM.
// Accepts one request at a time from IDLE and pulses valid or err.
module lsu_dmem
  import lsu_pkg::*;
#(
  parameter int n     = 32,
  parameter int alen  = 8,
  parameter int WAITC = DEF_WAITC
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [2:0]   funct3,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] wdata,
  output logic         busy,
  output logic         valid,
  output logic [n-1:0] rdata,
  output logic         err
);

  localparam int AW = alen + 2;
  localparam logic [3:0] LOAD =
    (WAITC == 0) ? 4'd0 : 4'(WAITC - 1);

  state_t          r_state;
  state_t          w_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [AW-1:0]   r_addr;
  logic [n-1:0]    r_wdata;
  logic [n-1:0]    r_rdata;

  logic            w_idle;
  logic            w_acc;
  logic            w_legal;
  logic            w_go_now;
  logic            w_go_wait;
  logic            w_go;
  logic            w_we;
  logic [2:0]      w_f3;
  logic [AW-1:0]   w_a;
  logic [n-1:0]    w_wd;
  logic [n-1:0]    w_lane_wd;
  logic [3:0]      w_be;
  logic [n-1:0]    w_q;
  logic [n-1:0]    w_sh;
  logic [n-1:0]    w_ext;
  logic            w_ld_done;
  logic            w_unused_addr;

  assign w_unused_addr = ^addr[n-1:AW];

  assign w_idle  = (r_state == IDLE);
  assign w_acc   = w_idle & req;
  assign w_legal = lsu_legal(we, funct3, addr[1:0]);

  // With no wait states the RAM is hit on the accept edge,
  // so the access fields come straight from the inputs.
  assign w_go_now  = w_acc & w_legal & (WAITC == 0);
  assign w_go_wait = (r_state == WAIT) & (r_cnt == 4'd0);
  assign w_go      = w_go_now | w_go_wait;

  assign w_we = w_go_now ? we          : r_we;
  assign w_f3 = w_go_now ? funct3      : r_f3;
  assign w_a  = w_go_now ? addr[AW-1:0] : r_addr;
  assign w_wd = w_go_now ? wdata       : r_wdata;

  assign w_lane_wd = w_wd << {w_a[1:0], 3'b000};

  always_comb begin
    w_be = 4'b1111;
    unique case (1'b1)
      (w_f3[1:0] == 2'b00): w_be = 4'b0001 << w_a[1:0];
      (w_f3[1:0] == 2'b01): w_be = w_a[1] ? 4'b1100 : 4'b0011;
      default:              w_be = 4'b1111;
    endcase
  end

  dmem_ram #(
    .n    (n),
    .alen (alen)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_go & w_we),
    .i_re    (w_go & ~w_we),
    .i_be    (w_be),
    .i_addr  (w_a[AW-1:2]),
    .i_wdata (w_lane_wd),
    .o_rdata (w_q)
  );

  assign w_sh = w_q >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_q;
    unique case (r_f3)
      LB:  w_ext = {{(n-8){w_sh[7]}}, w_sh[7:0]};
      LH:  w_ext = {{(n-16){w_sh[15]}}, w_sh[15:0]};
      LBU: w_ext = {{(n-8){1'b0}}, w_sh[7:0]};
      LHU: w_ext = {{(n-16){1'b0}}, w_sh[15:0]};
      default: w_ext = w_q;
    endcase
  end

  // Fresh load data is shown during DONE, then held in r_rdata.
  assign w_ld_done = (r_state == DONE) & ~r_we;
  assign rdata     = w_ld_done ? w_ext : r_rdata;

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req) begin
          if (!w_legal) begin
            w_nxt = ERR;
          end else if (WAITC == 0) begin
            w_nxt = DONE;
          end else begin
            w_nxt     = WAIT;
            w_cnt_nxt = LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE:    w_nxt = IDLE;
      ERR:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_acc) begin
      r_we    <= we;
      r_f3    <= funct3;
      r_addr  <= addr[AW-1:0];
      r_wdata <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
    end else if (w_ld_done) begin
      r_rdata <= w_ext;
    end
  end

  assign busy  = (r_state == WAIT);
  assign valid = (r_state == DONE);
  assign err   = (r_state == ERR);

endmodule

// File: tb/tb_lsu_dmem.sv
// Scoreboard bench for lsu_dmem: main DUT with one wait state,
// second DUT with three wait states for the reset-abort case.
module tb_lsu_dmem;

  localparam int WC = 1;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        rst_b = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;

  logic        busy, valid, err;
  logic [31:0] rdata;
  logic        busy3, valid3, err3;
  logic [31:0] rdata3;

  always #5 clock = ~clock;

  lsu_dmem #(.n(32), .alen(8), .WAITC(WC)) u_dut (
    .clock (clock), .reset (rst),
    .req (req), .we (we), .funct3 (funct3),
    .addr (addr), .wdata (wdata),
    .busy (busy), .valid (valid),
    .rdata (rdata), .err (err)
  );

  lsu_dmem #(.n(32), .alen(8), .WAITC(3)) u_dut3 (
    .clock (clock), .reset (rst_b),
    .req (req), .we (we), .funct3 (funct3),
    .addr (addr), .wdata (wdata),
    .busy (busy3), .valid (valid3),
    .rdata (rdata3), .err (err3)
  );

  typedef struct packed {
    logic [1:0]  ev;
    logic [31:0] d;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_val = 0;
  logic [31:0] mm [256];
  logic [31:0] last_rd = '0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit tb_legal(
    input bit w, input logic [2:0] f, input logic [1:0] a
  );
    case (f)
      3'b000:         return 1'b1;
      3'b001:         return (a[0] == 1'b0);
      3'b010:         return (a == 2'b00);
      3'b100, 3'b101: return !w;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(
    input logic [2:0] f, input logic [31:0] a
  );
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = mm[a[9:2]];
    case (a[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic m_store(
    input logic [2:0] f, input logic [31:0] a,
    input logic [31:0] d
  );
    logic [7:0] i;
    i = a[9:2];
    case (f)
      3'b000: begin
        case (a[1:0])
          2'd0:    mm[i][7:0]   = d[7:0];
          2'd1:    mm[i][15:8]  = d[7:0];
          2'd2:    mm[i][23:16] = d[7:0];
          default: mm[i][31:24] = d[7:0];
        endcase
      end
      3'b001: begin
        if (a[1]) mm[i][31:16] = d[15:0];
        else      mm[i][15:0]  = d[15:0];
      end
      default: mm[i] = d;
    endcase
  endtask

  task automatic push(
    input bit w, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] d
  );
    exp_t e;
    if (!tb_legal(w, f, a[1:0])) begin
      e.ev = 2'b10;
    end else begin
      e.ev = 2'b01;
      if (w) m_store(f, a, d);
      else   last_rd = m_load(f, a);
    end
    e.d = last_rd;
    q.push_back(e);
  endtask

  task automatic send(
    input bit w, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] d
  );
    push(w, f, a, d);
    @(negedge clock);
    req = 1'b1; we = w; funct3 = f;
    addr = a; wdata = d;
    @(posedge clock);
    #1 req = 1'b0;
  endtask

  task automatic txn(
    input bit w, input logic [2:0] f,
    input logic [31:0] a, input logic [31:0] d
  );
    int lat;
    int nb;
    bit done;
    bit ok;
    ok = tb_legal(w, f, a[1:0]);
    send(w, f, a, d);
    lat = 0; nb = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      if (busy) nb++;
      if (valid || err) done = 1'b1;
    end
    chk("latency", lat, ok ? WC + 1 : 1);
    chk("busy_cyc", nb, ok ? WC : 0);
    repeat (4) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (rst && (valid || err)) begin
      if (valid) n_val++;
      if (q.size() == 0) begin
        chk("sb_extra", {err, valid}, 0);
      end else begin
        m_e = q.pop_front();
        chk("sb_event", {err, valid}, m_e.ev);
        chk("sb_rdata", rdata, m_e.d);
      end
    end
  end

  initial begin
    int k;
    int nv0;
    int lat3;
    logic [2:0]  f;
    logic [31:0] a;
    bit w;

    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst3_rdata", rdata3, 0);
    rst = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clock);

    txn(1, 3'b010, 32'h10, 32'hDEADBEEF);
    txn(0, 3'b010, 32'h10, 32'h0);
    txn(0, 3'b000, 32'h13, 32'h0);
    txn(0, 3'b100, 32'h13, 32'h0);
    txn(0, 3'b001, 32'h10, 32'h0);
    txn(0, 3'b101, 32'h12, 32'h0);
    txn(1, 3'b000, 32'h11, 32'hABCD1255);
    txn(0, 3'b010, 32'h10, 32'h0);
    txn(0, 3'b010, 32'h12, 32'h0);
    txn(1, 3'b100, 32'h10, 32'h0);
    txn(1, 3'b001, 32'h11, 32'h0);
    txn(0, 3'b011, 32'h10, 32'h0);
    txn(0, 3'b010, 32'h10, 32'h0);
    txn(1, 3'b001, 32'h16, 32'h1234CAFE);
    txn(0, 3'b010, 32'h14, 32'h0);

    for (int i = 0; i < 8; i++) begin
      txn(1, 3'b010, 32'h40 + 4 * i, $urandom);
    end
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(0, 7);
      a = 32'h40 + 4 * $urandom_range(0, 7);
      case (k)
        0: begin f = 3'b000; w = 0; end
        1: begin f = 3'b001; w = 0; end
        2: begin f = 3'b010; w = 0; end
        3: begin f = 3'b100; w = 0; end
        4: begin f = 3'b101; w = 0; end
        5: begin f = 3'b000; w = 1; end
        6: begin f = 3'b001; w = 1; end
        default: begin f = 3'b010; w = 1; end
      endcase
      if (f[1:0] == 2'b00) a = a + $urandom_range(0, 3);
      if (f[1:0] == 2'b01) a = a + 2 * $urandom_range(0, 1);
      txn(w, f, a, $urandom);
    end

    txn(1, 3'b010, 32'h20, 32'hAAAA5555);
    txn(0, 3'b010, 32'h10, 32'h0);
    send(1, 3'b010, 32'h20, 32'h12345678);
    @(negedge clock);
    chk("r3_inwait", busy3, 1);
    rst_b = 1'b0;
    #1;
    chk("r3_busy", busy3, 0);
    chk("r3_valid", valid3, 0);
    chk("r3_err", err3, 0);
    chk("r3_rdata", rdata3, 0);
    repeat (2) @(negedge clock);
    rst_b = 1'b1;
    repeat (6) @(negedge clock);
    send(0, 3'b010, 32'h20, 32'h0);
    lat3 = 0;
    while (!valid3 && lat3 < 20) begin
      @(negedge clock);
      lat3++;
    end
    chk("r3_lat", lat3, 4);
    chk("r3_keep", rdata3, 32'hAAAA5555);
    repeat (4) @(negedge clock);

    nv0 = n_val;
    for (int i = 0; i < 3; i++) push(0, 3'b010, 32'h410, 32'h0);
    @(negedge clock);
    req = 1'b1; we = 1'b0; funct3 = 3'b010;
    addr = 32'h410; wdata = '0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    req = 1'b0;
    repeat (8) @(negedge clock);
    chk("hold_valids", n_val - nv0, 3);
    chk("sb_left", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
